// File: rtl/mod_regpack_fifo.sv
// Packs IN_BYTES-wide input beats into OUT_BYTES-wide blocks held in a DEPTH-slot FIFO.
// Optional macro PACK_FLUSH_EN adds early block close (i_flush) and a per-block byte count.
module mod_regpack_fifo #(
    parameter  int unsigned IN_BYTES  = 4,
    parameter  int unsigned OUT_BYTES = 16,
    parameter  int unsigned DEPTH     = 2,
    localparam int unsigned BEATS     = OUT_BYTES / IN_BYTES,
    localparam int unsigned BW        = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IN_BYTES*8-1:0]  i_data,
    input  logic                   i_valid,
    output logic                   i_ready,
    output logic [OUT_BYTES*8-1:0] o_data,
    output logic                   o_valid,
    input  logic                   o_ready,
`ifdef PACK_FLUSH_EN
    input  logic                   i_flush,
    output logic [$clog2(OUT_BYTES+1)-1:0] o_nbytes,
`endif
    output logic [CW-1:0]          o_count,
    output logic [BW-1:0]          beat_idx
);

    localparam int unsigned IW = IN_BYTES * 8;
    localparam int unsigned OW = OUT_BYTES * 8;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [OW-1:0] slot_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] beat_q;
    logic [OW-1:0] slot_wdata;
    logic          push, pop, close, flush;

`ifdef PACK_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // i_ready depends only on stored count, never on o_ready
    assign i_ready  = (count_q < CW'(DEPTH)) && !reset;
    assign o_valid  = (count_q != '0);
    assign o_data   = slot_q[rd_ptr_q];
    assign o_count  = count_q;
    assign beat_idx = beat_q;

    assign push  = i_valid && i_ready;
    assign pop   = o_valid && o_ready;
    assign close = push && ((beat_q == BW'(BEATS - 1)) || flush);

    // Merge the incoming beat into the slot being filled; a flush zeroes the tail
    always_comb begin
        slot_wdata = slot_q[wr_ptr_q];
        for (int b = 0; b < BEATS; b++) begin
            if (BW'(b) == beat_q) begin
                slot_wdata[b*IW +: IW] = i_data;
            end else if (flush && (BW'(b) > beat_q)) begin
                slot_wdata[b*IW +: IW] = '0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (close && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !close) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                slot_q[s] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
        end else begin
            if (push) begin
                slot_q[wr_ptr_q] <= slot_wdata;
                beat_q           <= close ? '0 : beat_q + 1'b1;
            end
            if (close) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

`ifdef PACK_FLUSH_EN
    localparam int unsigned NW = $clog2(OUT_BYTES + 1);

    logic [NW-1:0] nbytes_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                nbytes_q[s] <= '0;
            end
        end else if (close) begin
            nbytes_q[wr_ptr_q] <= flush ? NW'((int'(beat_q) + 1) * IN_BYTES) : NW'(OUT_BYTES);
        end
    end

    assign o_nbytes = nbytes_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_mod_regpack_fifo.sv
// Bench for mod_regpack_fifo: directed vector table on the 4/16/2 build plus a random
// scoreboard run on an 8/32/4 build; PACK_FLUSH_EN adds a flush sequence.
module tb_mod_regpack_fifo;

    logic         clk = 1'b0;
    logic         reset;
    // default build (4 -> 16 bytes, 2 slots)
    logic [31:0]  idata;
    logic         iv, ordy, flush;
    logic         irdy, ov;
    logic [127:0] od;
    logic [1:0]   cnt, bi;
    // wide build (8 -> 32 bytes, 4 slots)
    logic [63:0]  id2;
    logic         iv2, or2, irdy2, ov2;
    logic [255:0] od2;
    logic [2:0]   cnt2;
    logic [1:0]   bi2;
`ifdef PACK_FLUSH_EN
    logic [4:0]   nb;
    logic [5:0]   nb2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mod_regpack_fifo u_dut (
        .clk(clk), .reset(reset), .i_data(idata), .i_valid(iv), .i_ready(irdy),
        .o_data(od), .o_valid(ov), .o_ready(ordy),
`ifdef PACK_FLUSH_EN
        .i_flush(flush), .o_nbytes(nb),
`endif
        .o_count(cnt), .beat_idx(bi)
    );

    mod_regpack_fifo #(.IN_BYTES(8), .OUT_BYTES(32), .DEPTH(4)) u_wide (
        .clk(clk), .reset(reset), .i_data(id2), .i_valid(iv2), .i_ready(irdy2),
        .o_data(od2), .o_valid(ov2), .o_ready(or2),
`ifdef PACK_FLUSH_EN
        .i_flush(1'b0), .o_nbytes(nb2),
`endif
        .o_count(cnt2), .beat_idx(bi2)
    );

    typedef struct {
        bit rst; bit iv; int n; bit ordy;
        bit irdy; bit ov; int cnt; int bi; int blk;  // blk: -1 unchecked, -2 all zero
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit v, input int n, input bit r, input bit e_rdy,
                       input bit e_ov, input int e_cnt, input int e_bi, input int e_blk);
        vec_t t;
        t = '{rst, v, n, r, e_rdy, e_ov, e_cnt, e_bi, e_blk};
        tbl.push_back(t);
    endtask

    // Beat n carries bytes 4n..4n+3, so block j holds bytes 16j..16j+15
    function automatic logic [31:0] word(input int n);
        return {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)};
    endfunction

    function automatic logic [127:0] blk(input int j);
        return {word(4*j+3), word(4*j+2), word(4*j+1), word(4*j)};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hstep(input bit v, input int n, input bit r, input bit fl);
        iv = v; idata = word(n); ordy = r; flush = fl;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [255:0] q[$];
        logic [255:0] cur;
        int  mb, acc, cyc, fails0;
        bit  mrdy;

        reset = 1'b1; iv = 1'b0; idata = '0; ordy = 1'b0; flush = 1'b0;
        iv2 = 1'b0; id2 = '0; or2 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst i_ready", irdy, 0);
        chk("rst o_valid", ov, 0);
        chk("rst o_count", cnt, 0);
        chk("rst beat_idx", bi, 0);
        chk("rst o_data", od, 0);
        reset = 1'b0; #1;
        chk("release i_ready", irdy, 1);

        // basic block, stall/backpressure, completion+pop, mid-block reset
        add(0,1,0,1,  1,0,0,1,-1); add(0,1,1,1,  1,0,0,2,-1); add(0,1,2,1,  1,0,0,3,-1);
        add(0,1,3,1,  1,1,1,0, 0); add(0,0,0,1,  1,0,0,0,-1);
        add(0,1,4,0,  1,0,0,1,-1); add(0,1,5,0,  1,0,0,2,-1); add(0,1,6,0,  1,0,0,3,-1);
        add(0,1,7,0,  1,1,1,0, 1); add(0,1,8,0,  1,1,1,1, 1); add(0,1,9,0,  1,1,1,2, 1);
        add(0,1,10,0, 1,1,1,3, 1); add(0,1,11,0, 0,1,2,0, 1);
        for (int k = 0; k < 4; k++) add(0,1,12,0, 0,1,2,0, 1);
        add(0,1,12,1, 1,1,1,0, 2);
        add(0,1,12,0, 1,1,1,1, 2); add(0,1,13,0, 1,1,1,2, 2); add(0,1,14,0, 1,1,1,3, 2);
        add(0,1,15,1, 1,1,1,0, 3); add(0,0,0,1,  1,0,0,0,-1);
        add(0,1,16,1, 1,0,0,1,-1); add(0,1,17,1, 1,0,0,2,-1);
        add(1,0,0,1,  0,0,0,0,-2);
        add(0,1,20,1, 1,0,0,1,-1); add(0,1,21,1, 1,0,0,2,-1); add(0,1,22,1, 1,0,0,3,-1);
        add(0,1,23,1, 1,1,1,0, 5); add(0,0,0,1,  1,0,0,0,-1);

        foreach (tbl[i]) begin
            reset = tbl[i].rst; iv = tbl[i].iv; idata = word(tbl[i].n); ordy = tbl[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("v%0d i_ready", i), irdy, tbl[i].irdy);
            chk($sformatf("v%0d o_valid", i), ov, tbl[i].ov);
            chk($sformatf("v%0d o_count", i), cnt, tbl[i].cnt);
            chk($sformatf("v%0d beat_idx", i), bi, tbl[i].bi);
            if (tbl[i].blk != -1)
                chk($sformatf("v%0d o_data", i), od, (tbl[i].blk < 0) ? 128'h0 : blk(tbl[i].blk));
        end
        reset = 1'b0;

`ifdef PACK_FLUSH_EN
        // full block into slot 1, pop, then a 2-beat flushed block over stale slot 0
        for (int k = 24; k < 28; k++) hstep(1, k, 0, 0);
        chk("full o_nbytes", nb, 16);
        chk("full o_data", od, blk(6));
        hstep(0, 0, 1, 0);
        hstep(1, 28, 0, 0);
        hstep(1, 29, 0, 1);
        chk("flush o_valid", ov, 1);
        chk("flush o_count", cnt, 1);
        chk("flush beat_idx", bi, 0);
        chk("flush o_nbytes", nb, 8);
        chk("flush o_data", od, {64'h0, word(29), word(28)});
        hstep(0, 0, 1, 0);
        chk("flush popped", ov, 0);
`endif

        // random traffic on the wide build against a queue scoreboard
        iv = 1'b0; ordy = 1'b0;
        cur = '0; mb = 0; acc = 0; cyc = 0; fails0 = n_fail;
        while (acc < 1000 && cyc < 20000 && (n_fail - fails0) < 10) begin
            iv2 = ($urandom_range(0, 3) != 0);
            id2 = {$urandom, $urandom};
            or2 = ($urandom_range(0, 3) != 0);
            mrdy = (q.size() < 4);
            chk("rnd i_ready", irdy2, mrdy);
            chk("rnd o_valid", ov2, q.size() != 0);
            chk("rnd o_count", cnt2, q.size());
            chk("rnd o_count<=DEPTH", cnt2 <= 3'd4, 1);
            if (q.size() != 0) chk("rnd o_data", od2, q[0]);
            @(posedge clk); #1;
            if (q.size() != 0 && or2) void'(q.pop_front());
            if (iv2 && mrdy) begin
                cur[mb*64 +: 64] = id2;
                acc++;
                if (mb == 3) begin
                    q.push_back(cur);
                    mb = 0;
                end else begin
                    mb++;
                end
            end
            cyc++;
        end
        chk("rnd beats accepted", acc, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
